// File: rtl/axil_sram_slave.sv
// Word-organised AXI4-Lite SRAM slave: one transaction at a time with a fixed
// response latency. Out-of-range accesses complete with SLVERR.
module axil_sram_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          DEPTH     = 4096,
  parameter int          LATENCY   = 2,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_arvalid,
  output logic        mem_arready,
  input  logic [31:0] mem_araddr,
  output logic        mem_rvalid,
  input  logic        mem_rready,
  output logic [31:0] mem_rdata,
  output logic [1:0]  mem_rresp,
  input  logic        mem_awvalid,
  output logic        mem_awready,
  input  logic [31:0] mem_awaddr,
  input  logic        mem_wvalid,
  output logic        mem_wready,
  input  logic [31:0] mem_wdata,
  input  logic [7:0]  mem_wstrb,
  output logic        mem_bvalid,
  input  logic        mem_bready,
  output logic [1:0]  mem_bresp
);

  // state   | meaning
  // IDLE    | waiting for AR, or for AW and W together
  // RD_WAIT | counting down read latency
  // RD_RESP | rdata/rresp presented until R handshake
  // WR_WAIT | counting down write latency; commit happens on exit
  // WR_RESP | write committed, bresp presented until B handshake

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP} state_t;

  state_t        state, state_d;
  logic [3:0]    cnt;
  logic [AW-1:0] idx;
  logic          hit;
  logic [31:0]   wdata_q;
  logic [3:0]    wstrb_q;
  logic [31:0]   mem [DEPTH];

  logic          rd_start, wr_start, done;
  logic [31:0]   sel_addr, off;
  logic          sel_hit;
  logic          unused_bits;

  assign rd_start    = (state == IDLE) & mem_arvalid;
  assign wr_start    = (state == IDLE) & mem_awvalid & mem_wvalid & ~mem_arvalid;
  assign mem_arready = (state == IDLE);
  assign mem_awready = wr_start;
  assign mem_wready  = wr_start;
  assign done        = (cnt == 4'd0);

  // Only one address is latched per transaction, so decode through a shared mux.
  assign sel_addr = rd_start ? mem_araddr : mem_awaddr;
  assign off      = sel_addr - BASE_ADDR;
  assign sel_hit  = (sel_addr >= BASE_ADDR) && (off[31:AW+2] == '0);

  assign unused_bits = ^{off[1:0], mem_wstrb[7:4]};

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (rd_start)      state_d = RD_WAIT;
        else if (wr_start) state_d = WR_WAIT;
      end
      RD_WAIT: if (done)       state_d = RD_RESP;
      RD_RESP: if (mem_rready) state_d = IDLE;
      WR_WAIT: if (done)       state_d = WR_RESP;
      WR_RESP: if (mem_bready) state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      mem_rvalid <= 1'b0;
      mem_bvalid <= 1'b0;
      mem_rdata  <= '0;
      mem_rresp  <= 2'b00;
      mem_bresp  <= 2'b00;
    end else begin
      state <= state_d;
      case (state)
        IDLE: begin
          if (rd_start || wr_start) begin
            cnt <= 4'(LATENCY);
            idx <= off[AW+1:2];
            hit <= sel_hit;
          end
          if (wr_start) begin
            wdata_q <= mem_wdata;
            wstrb_q <= mem_wstrb[3:0];
          end
        end
        RD_WAIT: begin
          if (done) begin
            mem_rvalid <= 1'b1;
            mem_rdata  <= hit ? mem[idx] : '0;
            mem_rresp  <= hit ? 2'b00 : 2'b10;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RD_RESP: if (mem_rready) mem_rvalid <= 1'b0;
        WR_WAIT: begin
          if (done) begin
            mem_bvalid <= 1'b1;
            mem_bresp  <= hit ? 2'b00 : 2'b10;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        WR_RESP: if (mem_bready) mem_bvalid <= 1'b0;
        default: ;
      endcase
    end
  end

  // The array has no reset; a write still counting down when rst hits never lands.
  always_ff @(posedge clk) begin
    if (!rst && state == WR_WAIT && done && hit) begin
      for (int i = 0; i < 4; i++)
        if (wstrb_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_axil_sram_slave.sv
// Directed bench for axil_sram_slave: one LATENCY=2 instance for the main
// function, one LATENCY=0 instance for zero-wait timing.
module tb_axil_sram_slave;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] araddr, rdata;
  logic [1:0]  rresp, bresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] awaddr, wdata;
  logic [7:0]  wstrb;

  logic        arvalid0, arready0, rvalid0, rready0;
  logic [31:0] araddr0, rdata0;
  logic [1:0]  rresp0, bresp0;
  logic        awvalid0, awready0, wvalid0, wready0, bvalid0, bready0;
  logic [31:0] awaddr0, wdata0;
  logic [7:0]  wstrb0;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  axil_sram_slave #(.BASE_ADDR(BASE), .DEPTH(4096), .LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .mem_arvalid(arvalid), .mem_arready(arready), .mem_araddr(araddr),
    .mem_rvalid(rvalid), .mem_rready(rready), .mem_rdata(rdata), .mem_rresp(rresp),
    .mem_awvalid(awvalid), .mem_awready(awready), .mem_awaddr(awaddr),
    .mem_wvalid(wvalid), .mem_wready(wready), .mem_wdata(wdata), .mem_wstrb(wstrb),
    .mem_bvalid(bvalid), .mem_bready(bready), .mem_bresp(bresp)
  );

  axil_sram_slave #(.BASE_ADDR(BASE), .DEPTH(16), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst),
    .mem_arvalid(arvalid0), .mem_arready(arready0), .mem_araddr(araddr0),
    .mem_rvalid(rvalid0), .mem_rready(rready0), .mem_rdata(rdata0), .mem_rresp(rresp0),
    .mem_awvalid(awvalid0), .mem_awready(awready0), .mem_awaddr(awaddr0),
    .mem_wvalid(wvalid0), .mem_wready(wready0), .mem_wdata(wdata0), .mem_wstrb(wstrb0),
    .mem_bvalid(bvalid0), .mem_bready(bready0), .mem_bresp(bresp0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk)
    if (rvalid & bvalid) chk("r_b_exclusive", 32'(rvalid & bvalid), 32'd0);

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [7:0] s,
                    output int lat, output logic [1:0] resp);
    int n;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    #1;
    n = 0;
    while (!awready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    lat = 0;
    while (!bvalid && lat < 50) begin @(posedge clk); #1; lat++; end
    resp = bresp;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d,
                    output logic [1:0] resp, output int lat);
    int n;
    araddr = a; arvalid = 1'b1;
    #1;
    n = 0;
    while (!arready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    arvalid = 1'b0;
    lat = 0;
    while (!rvalid && lat < 50) begin @(posedge clk); #1; lat++; end
    d = rdata; resp = rresp;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  initial begin
    logic [31:0] d, held;
    logic [1:0]  resp;
    int          lat, n;

    rst = 1'b1;
    {arvalid, rready, awvalid, wvalid, bready} = '0;
    {arvalid0, rready0, awvalid0, wvalid0, bready0} = '0;
    araddr = '0; awaddr = '0; wdata = '0; wstrb = '0;
    araddr0 = '0; awaddr0 = '0; wdata0 = '0; wstrb0 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_resp", {28'd0, rresp, bresp}, 32'd0);
    chk("rst_arready", 32'(arready), 32'd1);

    // full-word write then read-back, latency 2 -> 3 cycles after handshake
    wr(BASE + 32'h10, 32'hDEADBEEF, 8'h0F, lat, resp);
    chk("wr_lat", 32'(lat), 32'd3);
    chk("wr_bresp", 32'(resp), 32'd0);
    rd(BASE + 32'h10, d, resp, lat);
    chk("rd_lat", 32'(lat), 32'd3);
    chk("rd_data", d, 32'hDEADBEEF);
    chk("rd_rresp", 32'(resp), 32'd0);

    // byte strobes
    wr(BASE + 32'h10, 32'h0000_1234, 8'h03, lat, resp);
    rd(BASE + 32'h10, d, resp, lat);
    chk("strb03", d, 32'hDEAD1234);
    wr(BASE + 32'h10, 32'hFFFF_FFFF, 8'hF0, lat, resp);
    chk("strbF0_bresp", 32'(resp), 32'd0);
    rd(BASE + 32'h10, d, resp, lat);
    chk("strbF0", d, 32'hDEAD1234);
    wr(BASE + 32'h10, 32'hFFFF_FFFF, 8'h00, lat, resp);
    chk("strb00_bresp", 32'(resp), 32'd0);
    rd(BASE + 32'h10, d, resp, lat);
    chk("strb00", d, 32'hDEAD1234);

    // read backpressure
    araddr = BASE + 32'h10; arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin @(posedge clk); #1; n++; end
    held = rdata;
    chk("bp_first", held, 32'hDEAD1234);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_rvalid", 32'(rvalid), 32'd1);
      chk("bp_rdata", rdata, held);
      chk("bp_arready", 32'(arready), 32'd0);
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    chk("bp_arready_after", 32'(arready), 32'd1);
    chk("bp_rvalid_after", 32'(rvalid), 32'd0);

    // simultaneous read and write: read first, write on next IDLE cycle
    araddr = BASE + 32'h10; arvalid = 1'b1;
    awaddr = BASE + 32'h20; wdata = 32'hCAFEF00D; wstrb = 8'h0F;
    awvalid = 1'b1; wvalid = 1'b1;
    #1;
    chk("prio_awready", 32'(awready), 32'd0);
    chk("prio_arready", 32'(arready), 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin @(posedge clk); #1; n++; end
    chk("prio_rdata", rdata, 32'hDEAD1234);
    chk("prio_awready_rresp", 32'(awready), 32'd0);
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    chk("prio_awready_idle", 32'(awready), 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin @(posedge clk); #1; n++; end
    chk("prio_blat", 32'(n), 32'd3);
    chk("prio_bresp", 32'(bresp), 32'd0);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    rd(BASE + 32'h20, d, resp, lat);
    chk("prio_readback", d, 32'hCAFEF00D);

    // out-of-range accesses
    wr(BASE, 32'h0BAD_C0DE, 8'h0F, lat, resp);
    rd(32'h7FFF_FFFC, d, resp, lat);
    chk("oor_lo_rresp", 32'(resp), 32'd2);
    chk("oor_lo_rdata", d, 32'd0);
    chk("oor_lo_lat", 32'(lat), 32'd3);
    wr(BASE + 32'h4000, 32'h1111_1111, 8'h0F, lat, resp);
    chk("oor_hi_bresp", 32'(resp), 32'd2);
    chk("oor_hi_wlat", 32'(lat), 32'd3);
    wr(32'h7FFF_FFFC, 32'h2222_2222, 8'h0F, lat, resp);
    chk("oor_lo_bresp", 32'(resp), 32'd2);
    rd(BASE + 32'h4000, d, resp, lat);
    chk("oor_hi_rresp", 32'(resp), 32'd2);
    chk("oor_hi_rdata", d, 32'd0);
    rd(BASE, d, resp, lat);
    chk("word0_intact", d, 32'h0BAD_C0DE);
    chk("word0_rresp", 32'(resp), 32'd0);

    // reset while a write is still waiting
    awaddr = BASE + 32'h10; wdata = 32'h5555_5555; wstrb = 8'h0F;
    awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstw_bvalid", 32'(bvalid), 32'd0);
    chk("rstw_idle", 32'(arready), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("rstw_bvalid_late", 32'(bvalid), 32'd0);
    rd(BASE + 32'h10, d, resp, lat);
    chk("rstw_word", d, 32'hDEAD1234);

    // zero-latency instance
    awaddr0 = BASE + 32'h4; wdata0 = 32'hA5A5_0F0F; wstrb0 = 8'h0F;
    awvalid0 = 1'b1; wvalid0 = 1'b1;
    #1;
    chk("l0_awready", 32'(awready0), 32'd1);
    @(posedge clk); #1;
    awvalid0 = 1'b0; wvalid0 = 1'b0;
    chk("l0_bvalid_T", 32'(bvalid0), 32'd0);
    @(posedge clk); #1;
    chk("l0_bvalid_T1", 32'(bvalid0), 32'd1);
    bready0 = 1'b1;
    @(posedge clk); #1;
    bready0 = 1'b0;
    araddr0 = BASE + 32'h4; arvalid0 = 1'b1;
    @(posedge clk); #1;
    arvalid0 = 1'b0;
    chk("l0_rvalid_T", 32'(rvalid0), 32'd0);
    @(posedge clk); #1;
    chk("l0_rvalid_T1", 32'(rvalid0), 32'd1);
    chk("l0_rdata", rdata0, 32'hA5A5_0F0F);
    rready0 = 1'b1;
    @(posedge clk); #1;
    rready0 = 1'b0;
    chk("l0_rvalid_done", 32'(rvalid0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
